// File: rtl/sysid_check_ctrl_if.sv
// sysid_check_ctrl_if
// Bundles the two buses around the system-ID checker:
//   - the read-only ID slave port (word select, read strobe, read data)
//   - the CPU-facing Avalon-MM CSR slave port
// Modports:
//   master : the checker side (drives the ID slave, answers CSR accesses)
//   slave  : the environment side (ID slave model plus CSR host)
// Signals:
//   sysid_address   1   ID slave word select (0 = system ID, 1 = timestamp)
//   sysid_read      1   ID slave read strobe
//   sysid_readdata  32  ID slave read data
//   csr_address     2   CSR word select
//   csr_read        1   CSR read strobe
//   csr_write       1   CSR write strobe
//   csr_writedata   32  CSR write data
//   csr_readdata    32  CSR read data, combinational, zero wait states
interface sysid_check_ctrl_if;
  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;
  logic [1:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;

  modport master (
    output sysid_address,
    output sysid_read,
    input  sysid_readdata,
    input  csr_address,
    input  csr_read,
    input  csr_write,
    input  csr_writedata,
    output csr_readdata
  );

  modport slave (
    input  sysid_address,
    input  sysid_read,
    output sysid_readdata,
    output csr_address,
    output csr_read,
    output csr_write,
    output csr_writedata,
    input  csr_readdata
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl
// Boot-time and on-demand checker for the read-only system-ID slave. After
// reset it reads ID word 0 (system ID) and word 1 (build timestamp), compares
// both with compile-time values, retries on mismatch and reports the verdict
// on sideband outputs and a small CSR slave. It only reports; it gates nothing.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   bus         if   sysid_check_ctrl_if.master (ID slave + CSR slave)
//   check_done  out  a check completed since the last start
//   check_pass  out  last completed check matched both words
//
// CSR map:
//   0: [0] done [1] pass [2] id_mismatch [3] ts_mismatch [4] busy
//      [11:8] retry_count; write bit0=1 while done starts a new check
//   1: captured ID   2: captured timestamp   3: {16'b0, check_count}
//
// Optional feature: define SYSID_CHECK_PERIODIC_EN to re-run a passing check
// automatically every PERIOD clocks spent in DONE.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5748_B343,
  parameter int          READ_LATENCY       = 0,
  parameter int          MAX_RETRIES        = 3,
  parameter int          PERIOD             = 1000000
) (
  input  logic                clock,
  input  logic                reset_n,
  sysid_check_ctrl_if.master  bus,
  output logic                check_done,
  output logic                check_pass
);

  typedef enum logic [2:0] {
    START,
    ISSUE_ID,
    WAIT_ID,
    ISSUE_TS,
    WAIT_TS,
    EVAL,
    DONE
  } state_t;

  localparam bit         LAT_ZERO      = (READ_LATENCY == 0);
  localparam logic [1:0] WAIT_LAST     = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRIES);

  state_t      state;
  state_t      state_next;

  logic        done_q;
  logic        pass_q;
  logic        busy_q;
  logic        id_mismatch;
  logic        ts_mismatch;
  logic [3:0]  retry_count;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;
  logic [15:0] check_count;
  logic [1:0]  wait_count;

  logic        capture_id;
  logic        capture_ts;
  logic        enter_done;
  logic        retry;
  logic        restart;
  logic        start_req;
  logic        auto_start;
  logic        id_match;
  logic        ts_match;

  assign id_match  = (captured_id == EXPECTED_ID);
  assign ts_match  = (captured_ts == EXPECTED_TIMESTAMP);
  assign start_req = bus.csr_write && (bus.csr_address == 2'd0) && bus.csr_writedata[0];

  // Read strobes come straight from the state so an asynchronous reset
  // removes them immediately.
  assign bus.sysid_read    = (state == ISSUE_ID) || (state == ISSUE_TS);
  assign bus.sysid_address = (state == ISSUE_TS);

  assign check_done = done_q;
  assign check_pass = pass_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= START;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes for the datapath.
  always_comb begin
    state_next = state;
    capture_id = 1'b0;
    capture_ts = 1'b0;
    enter_done = 1'b0;
    retry      = 1'b0;
    restart    = 1'b0;
    case (state)
      START: begin
        state_next = ISSUE_ID;
      end
      ISSUE_ID: begin
        if (LAT_ZERO) begin
          capture_id = 1'b1;
          state_next = ISSUE_TS;
        end else begin
          state_next = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (wait_count == WAIT_LAST) begin
          capture_id = 1'b1;
          state_next = ISSUE_TS;
        end
      end
      ISSUE_TS: begin
        if (LAT_ZERO) begin
          capture_ts = 1'b1;
          state_next = EVAL;
        end else begin
          state_next = WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (wait_count == WAIT_LAST) begin
          capture_ts = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (id_match && ts_match) begin
          enter_done = 1'b1;
          state_next = DONE;
        end else if (retry_count < MAX_RETRY_CNT) begin
          retry      = 1'b1;
          state_next = ISSUE_ID;
        end else begin
          enter_done = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start_req || auto_start) begin
          restart    = 1'b1;
          state_next = ISSUE_ID;
        end
      end
      default: begin
        state_next = START;
      end
    endcase
  end

  // Read-latency counter; it idles at zero so each WAIT state starts fresh.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_count <= 2'd0;
    end else if (((state == WAIT_ID) || (state == WAIT_TS)) && (wait_count != WAIT_LAST)) begin
      wait_count <= wait_count + 2'd1;
    end else begin
      wait_count <= 2'd0;
    end
  end

  // Captured data, verdict flags and counters. busy is registered so that
  // every CSR word reads zero while reset is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      retry_count <= 4'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      check_count <= 16'd0;
    end else begin
      busy_q <= (state_next != DONE);
      if (capture_id) begin
        captured_id <= bus.sysid_readdata;
      end
      if (capture_ts) begin
        captured_ts <= bus.sysid_readdata;
      end
      if (state == EVAL) begin
        id_mismatch <= !id_match;
        ts_mismatch <= !ts_match;
      end
      if (retry) begin
        retry_count <= retry_count + 4'd1;
      end
      if (enter_done) begin
        done_q      <= 1'b1;
        pass_q      <= id_match && ts_match;
        check_count <= check_count + 16'd1;
      end
      if (restart) begin
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        retry_count <= 4'd0;
      end
    end
  end

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);

  logic [31:0] period_count;

  // Dwell counter in a passing DONE; restarted on every DONE entry so the
  // next automatic check begins exactly PERIOD cycles after the last verdict.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_count <= 32'd0;
    end else if (enter_done) begin
      period_count <= 32'd0;
    end else if ((state == DONE) && pass_q) begin
      period_count <= period_count + 32'd1;
    end
  end

  assign auto_start = (state == DONE) && pass_q && (period_count == PERIOD_LAST);
`else
  logic [31:0] unused_period;

  assign auto_start    = 1'b0;
  assign unused_period = 32'(PERIOD);
`endif

  logic [31:0] unused_csr;
  assign unused_csr = {bus.csr_read, bus.csr_writedata[31:1]};

  // CSR read mux, purely combinational from registers so a same-cycle write
  // is not visible until the following cycle.
  always_comb begin
    bus.csr_readdata = 32'd0;
    case (bus.csr_address)
      2'd0: bus.csr_readdata = {20'd0, retry_count, 3'd0, busy_q,
                                ts_mismatch, id_mismatch, pass_q, done_q};
      2'd1: bus.csr_readdata = captured_id;
      2'd2: bus.csr_readdata = captured_ts;
      2'd3: bus.csr_readdata = {16'd0, check_count};
      default: bus.csr_readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl
// Scoreboard bench for sysid_check_ctrl. Each planned check pushes the
// expected read-address sequence and verdict; a monitor pops and compares
// whenever the DUT strobes a read or raises check_done. The ID slave model
// returns planned data only on the capture cycle and random data otherwise.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5748_B343;
  localparam int LAT = 2;
  localparam int MAXR = 3;
  localparam int ATTEMPT_CYCLES = 3 + 2 * LAT;

  typedef struct {
    logic        pass;
    logic [3:0]  retry;
    logic        idm;
    logic        tsm;
    logic [31:0] id;
    logic [31:0] ts;
    logic [15:0] count;
    int          done_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic check_done;
  logic check_pass;

  sysid_check_ctrl_if bus ();

  sysid_check_ctrl #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(LAT),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .check_done(check_done),
    .check_pass(check_pass)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int model_count = 0;

  exp_t        exp_q[$];
  logic        addr_q[$];
  logic [31:0] id_src[$];
  logic [31:0] ts_src[$];

  int          remain = -1;
  logic [31:0] pend = 32'd0;
  logic        prev_done = 1'b0;
  exp_t        mon_e;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a check is a list of attempts; the first fully matching
  // attempt passes, otherwise it fails after MAXR+1 attempts.
  task automatic planCheck(input int n_bad_in, input int kind_in, input int base, output exp_t e);
    int n_bad;
    int attempts;
    int kind;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    n_bad = (n_bad_in < 0) ? int'($urandom_range(0, MAXR + 1)) : n_bad_in;
    attempts = (n_bad > MAXR) ? MAXR + 1 : n_bad + 1;
    id_v = EXP_ID;
    ts_v = EXP_TS;
    for (int a = 0; a < attempts; a++) begin
      id_v = EXP_ID;
      ts_v = EXP_TS;
      if (a < n_bad) begin
        kind = (kind_in < 0) ? int'($urandom_range(0, 2)) : kind_in;
        if (kind != 1) id_v = EXP_ID ^ ($urandom | 32'h1);
        if (kind != 0) ts_v = EXP_TS ^ ($urandom | 32'h1);
      end
      id_src.push_back(id_v);
      ts_src.push_back(ts_v);
      addr_q.push_back(1'b0);
      addr_q.push_back(1'b1);
    end
    model_count = (model_count + 1) % 65536;
    e.pass     = (n_bad <= MAXR);
    e.retry    = 4'(attempts - 1);
    e.idm      = (id_v != EXP_ID);
    e.tsm      = (ts_v != EXP_TS);
    e.id       = id_v;
    e.ts       = ts_v;
    e.count    = 16'(model_count);
    e.done_cyc = base + 1 + attempts * ATTEMPT_CYCLES;
    exp_q.push_back(e);
  endtask

  task automatic readCsr(input logic [1:0] a, output logic [31:0] d);
    bus.csr_address = a;
    #1;
    d = bus.csr_readdata;
  endtask

  task automatic checkCsr(input exp_t e);
    logic [31:0] d;
    checkOutput("done_level", check_done, 1'b1);
    readCsr(2'd0, d);
    checkOutput("csr_status", d, {20'd0, e.retry, 3'd0, 1'b0, e.tsm, e.idm, e.pass, 1'b1});
    readCsr(2'd1, d);
    checkOutput("csr_id", d, e.id);
    readCsr(2'd2, d);
    checkOutput("csr_ts", d, e.ts);
    readCsr(2'd3, d);
    checkOutput("csr_count", d, {16'd0, e.count});
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (!check_done && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done_timeout", check_done, 1'b1);
  endtask

  task automatic flushModel();
    exp_q.delete();
    addr_q.delete();
    id_src.delete();
    ts_src.delete();
    model_count = 0;
  endtask

  // Issue a CSR start from DONE, optionally poke a second start while busy,
  // then wait for the verdict and compare the CSR view.
  task automatic applyStimulus(input int n_bad_in, input int kind_in, input bit busy_poke, output exp_t e);
    logic [31:0] d;
    @(negedge clock);
    planCheck(n_bad_in, kind_in, cyc, e);
    bus.csr_address   = 2'd0;
    bus.csr_writedata = $urandom | 32'h1;
    bus.csr_write     = 1'b1;
    @(negedge clock);
    bus.csr_write     = 1'b0;
    bus.csr_writedata = 32'd0;
    checkOutput("done_cleared", check_done, 1'b0);
    readCsr(2'd0, d);
    checkOutput("status_after_start", d, 32'h0000_0010);
    if (busy_poke) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      readCsr(2'd0, d);
      checkOutput("busy_bit", d[4], 1'b1);
      bus.csr_address   = 2'd0;
      bus.csr_writedata = 32'h1;
      bus.csr_write     = 1'b1;
      @(negedge clock);
      bus.csr_write     = 1'b0;
      bus.csr_writedata = 32'd0;
    end
    waitDone(200);
    checkCsr(e);
  endtask

  // ID slave model: data appears only in the capture cycle, LAT cycles after
  // the read strobe; every other cycle carries random noise.
  always @(negedge clock) begin
    if (!reset_n) begin
      remain = -1;
      bus.sysid_readdata = $urandom;
    end else begin
      if (bus.sysid_read) begin
        remain = LAT;
        if (bus.sysid_address == 1'b0) pend = (id_src.size() > 0) ? id_src.pop_front() : $urandom;
        else                           pend = (ts_src.size() > 0) ? ts_src.pop_front() : $urandom;
      end
      if (remain == 0) begin
        bus.sysid_readdata = pend;
        remain = -1;
      end else begin
        bus.sysid_readdata = $urandom;
        if (remain > 0) remain--;
      end
    end
  end

  // Monitor: compares each read strobe and each verdict against the queues.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.sysid_read) begin
        checkOutput("read_pending", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) checkOutput("read_addr", bus.sysid_address, addr_q.pop_front());
      end
      if (check_done && !prev_done) begin
        checkOutput("done_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
          checkOutput("check_pass", check_pass, mon_e.pass);
        end
      end
      prev_done = check_done;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic [31:0] d;
    int n;
    bus.csr_address    = 2'd0;
    bus.csr_read       = 1'b0;
    bus.csr_write      = 1'b0;
    bus.csr_writedata  = 32'd0;
    bus.sysid_readdata = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("reset_sysid_read", bus.sysid_read, 1'b0);
    checkOutput("reset_sysid_address", bus.sysid_address, 1'b0);
    checkOutput("reset_check_done", check_done, 1'b0);
    checkOutput("reset_check_pass", check_pass, 1'b0);
    for (int a = 0; a < 4; a++) begin
      readCsr(2'(a), d);
      checkOutput($sformatf("reset_csr%0d", a), d, 32'd0);
    end

    // Boot check: matching slave.
    planCheck(0, 0, cyc, e);
    reset_n = 1'b1;
    waitDone(200);
    checkCsr(e);

    // Non-start writes in DONE must change nothing.
    @(negedge clock);
    bus.csr_address   = 2'd0;
    bus.csr_writedata = $urandom & 32'hFFFF_FFFE;
    bus.csr_write     = 1'b1;
    for (int a = 1; a < 4; a++) begin
      @(negedge clock);
      bus.csr_address   = 2'(a);
      bus.csr_writedata = $urandom;
    end
    @(negedge clock);
    bus.csr_write = 1'b0;
    @(negedge clock);
    checkCsr(e);

    // ID wrong on every attempt, then TS wrong once followed by a match.
    applyStimulus(MAXR + 1, 0, 1'b0, e);
    applyStimulus(1, 1, 1'b1, e);

    // Reset while the TS read strobe is high.
    @(negedge clock);
    planCheck(1, 2, cyc, e);
    bus.csr_address   = 2'd0;
    bus.csr_writedata = 32'h1;
    bus.csr_write     = 1'b1;
    @(negedge clock);
    bus.csr_write     = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.sysid_read && bus.sysid_address) && n < 60);
    checkOutput("reached_issue_ts", bus.sysid_read & bus.sysid_address, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_sysid_read", bus.sysid_read, 1'b0);
    checkOutput("midreset_check_done", check_done, 1'b0);
    checkOutput("midreset_check_pass", check_pass, 1'b0);
    for (int a = 0; a < 4; a++) begin
      readCsr(2'(a), d);
      checkOutput($sformatf("midreset_csr%0d", a), d, 32'd0);
    end
    flushModel();
    @(negedge clock);
    planCheck(-1, -1, cyc, e);
    reset_n = 1'b1;
    waitDone(200);
    checkCsr(e);

    // Randomized checks.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(-1, -1, 1'($urandom_range(0, 1)), e);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    @(negedge clock);
    checkOutput("verdicts_drained", exp_q.size(), 32'd0);
    checkOutput("reads_drained", addr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Boot-time and on-demand checker for the read-only system-ID slave. After reset it sequences two reads of the ID slave (word 0 = system ID, word 1 = build timestamp), compares both against compile-time expected values, retries on mismatch, and reports pass/fail on sideband outputs and a small CPU-visible Avalon-MM CSR slave. It sits between the ID slave and the processor's peripheral interconnect. It gates nothing; it only reports.

## Interface
- EXPECTED_ID, 32'h00000000, value required at ID word 0
- EXPECTED_TIMESTAMP, 32'h5748B343, value required at ID word 1
- READ_LATENCY, 0, cycles from the read-issue cycle to valid `sysid_readdata`; legal range 0..3
- MAX_RETRIES, 3, extra attempts after a failed first attempt; legal range 0..15
- PERIOD, 1000000, re-check interval in clocks; used only with the macro

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sysid_address  out  1  ID slave word select
- sysid_read  out  1  ID slave read strobe
- sysid_readdata  in  32  ID slave data
- csr_address  in  2  CSR word select
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data; combinational, zero wait states
- check_done  out  1  a check completed since the last start
- check_pass  out  1  last completed check matched both words

## Operation
- FSM states: START, ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS, EVAL, DONE. Reset state is START.
- START: go to ISSUE_ID on the next edge. `busy` is 1 in every state except DONE.
- ISSUE_x: `sysid_read`=1 and `sysid_address`=0 for ID or 1 for TS, for exactly one cycle.
  - If READ_LATENCY=0, capture `sysid_readdata` on that edge and skip WAIT_x.
- WAIT_x: count READ_LATENCY cycles. Capture data on the last one.
- EVAL: set `id_mismatch` and `ts_mismatch` from the compares.
  - Both match: go to DONE with pass=1.
  - Any mismatch and retry_count<MAX_RETRIES: increment retry_count, go to ISSUE_ID.
  - Otherwise: go to DONE with pass=0.
- DONE: `check_done`=1. The 16-bit check_count increments on entry and wraps at 0xFFFF→0.
- CSR map (read data is combinational from registers):
  - Word 0: [0] done, [1] pass, [2] id_mismatch, [3] ts_mismatch, [4] busy, [11:8] retry_count, other bits 0.
  - Word 1: captured ID.
  - Word 2: captured timestamp.
  - Word 3: {16'b0, check_count}.
- CSR start: a write to word 0 with bit0=1.
  - In DONE: clears done, pass, mismatches and retry_count, then goes to ISSUE_ID on the next edge.
  - In any other state: ignored.
- Writes to words 1–3 are ignored.
- A CSR read and a write in the same cycle return the pre-write value.

## Timing
- Reset values: every register 0, state START. Outputs are therefore 0 (`sysid_read`, `sysid_address`, `check_done`, `check_pass`), and `csr_readdata` is 0 for every address.
- Reset is asynchronous. Asserting it mid-operation drops `sysid_read` immediately and discards captured data. Release starts a fresh check.
- One attempt = 3+2·READ_LATENCY cycles (ISSUE_ID through EVAL).
- First check: `check_done` rises after edge 4+2·READ_LATENCY following reset release. Each retry adds 3+2·READ_LATENCY cycles.
- `check_done` and `check_pass` are registered and change together on entry to DONE. Both clear on the edge that accepts a start.
- `sysid_readdata` is sampled only on capture edges. It is don't-care otherwise.

## Configuration
- SYSID_CHECK_PERIODIC_EN defined:
  - In DONE with pass=1, a 32-bit counter counts PERIOD cycles, then the FSM auto-starts a new check with the same clearing as a CSR start.
  - The counter resets on every DONE entry.
  - A CSR start preempts the counter.
  - No auto-restart after a fail.
- SYSID_CHECK_PERIODIC_EN undefined: DONE is left only by a CSR start or reset. The counter is not built.

## Test plan
- Matching slave (ID=0, TS=0x5748B343), READ_LATENCY=0 -> reads at address 0 then 1 on edges 2 and 3; done=pass=1 after edge 4; CSR word 0 reads 0x00000003; word 3 reads 1.
- ID slave always returns ID=0x1 -> 4 attempts (8 reads); done=1, pass=0; word 0 reads 0x00000305.
- First attempt has TS wrong, second matches -> pass=1, retry_count=1, word 0 reads 0x00000103, word 2 reads 0x5748B343.
- READ_LATENCY=2 -> `sysid_read` is 1-cycle pulses; done after edge 8. Data changed outside capture edges does not affect the result.
- CSR start written while busy -> ignored. Start in DONE -> done falls next edge, new check passes, check_count=2. Reset asserted during WAIT_TS -> all outputs 0 immediately; clean check after release.
- With SYSID_CHECK_PERIODIC_EN and PERIOD=16 -> a new ISSUE_ID starts 16 cycles after DONE entry, and check_count increments. No restart occurs after a failed check.
